// File: rtl/edge_latch_bank.sv
// edge_latch_bank: a bank of per-channel latches set and cleared by edges on
// asynchronous request lines. A level acknowledge clears each latch, and each
// channel has a saturating overrun counter for set events that find the latch
// already set.
module edge_latch_bank #(
    parameter int           W           = 8,
    parameter int           CW          = 4,
    parameter int           SYNC_STAGES = 2,
    parameter logic [W-1:0] SET_POL     = '1,
    parameter logic [W-1:0] CLR_POL     = '1,
    parameter bit           SET_WINS    = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [W-1:0]    i_set,
    input  logic [W-1:0]    i_clear,
    input  logic [W-1:0]    i_ack,
    output logic [W-1:0]    o_out,
    output logic            o_any,
    output logic [W*CW-1:0] o_ovr,
    output logic [W-1:0]    o_ovr_flag
);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [1:0]    PRIME_LAST = 2'(SYNC_STAGES);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    state_t               state;
    logic [1:0]           prime_cnt;
    logic                 run;

    logic [W-1:0]         set_cur;
    logic [W-1:0]         clr_cur;
    logic [W-1:0]         set_hist;
    logic [W-1:0]         clr_hist;
    logic [W-1:0]         set_edge;
    logic [W-1:0]         clr_edge;

    logic [W-1:0]         out_nxt;
    logic [W-1:0]         flag_nxt;
    logic [W-1:0][CW-1:0] cnt_q;
    logic [W-1:0][CW-1:0] cnt_nxt;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign set_cur = i_set;
            assign clr_cur = i_clear;
        end else begin : g_sync
            logic [W-1:0] set_sync [SYNC_STAGES];
            logic [W-1:0] clr_sync [SYNC_STAGES];

            // Shift the raw set/clear requests through the synchroniser chain.
            // NOTE: sequential state uses non-blocking assignments so each stage
            // samples its neighbour's pre-edge value and the chain really shifts.
            // NOTE: the synchroniser flops are reset as well, so an edge captured
            // before reset can never surface after it.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        set_sync[i] <= '0;
                        clr_sync[i] <= '0;
                    end
                end else begin
                    set_sync[0] <= i_set;
                    clr_sync[0] <= i_clear;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        set_sync[i] <= set_sync[i-1];
                        clr_sync[i] <= clr_sync[i-1];
                    end
                end
            end

            assign set_cur = set_sync[SYNC_STAGES-1];
            assign clr_cur = clr_sync[SYNC_STAGES-1];
        end
    endgenerate

    // One-flop history of the synchronised levels, used for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            set_hist <= '0;
            clr_hist <= '0;
        end else begin
            set_hist <= set_cur;
            clr_hist <= clr_cur;
        end
    end

    // Stay in PRIME for SYNC_STAGES+1 clocks so the chain and history fill with
    // the present input levels before any edge is believed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            case (state)
                PRIME: begin
                    if (prime_cnt == PRIME_LAST) begin
                        state <= RUN;
                    end else begin
                        prime_cnt <= prime_cnt + 2'd1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= PRIME;
            endcase
        end
    end

    assign run = (state == RUN);

    // Per-channel polarity selects rising or falling edges; no edges while priming.
    always_comb begin
        set_edge = '0;
        clr_edge = '0;
        if (run) begin
            set_edge = (SET_POL & set_cur & ~set_hist) | (~SET_POL & ~set_cur & set_hist);
            clr_edge = (CLR_POL & clr_cur & ~clr_hist) | (~CLR_POL & ~clr_cur & clr_hist);
        end
    end

    // Next latch and counter state: edge resolution first, then acknowledge.
    // NOTE: every always_comb target is given a default first so no latch is inferred.
    always_comb begin
        out_nxt  = o_out;
        cnt_nxt  = cnt_q;
        flag_nxt = '0;
        for (int n = 0; n < W; n++) begin
            if (set_edge[n] && clr_edge[n]) begin
                out_nxt[n] = SET_WINS;
            end else if (set_edge[n]) begin
                out_nxt[n] = 1'b1;
            end else if (clr_edge[n]) begin
                out_nxt[n] = 1'b0;
            end

            // An ack drops the latch, but never swallows a set arriving with it.
            if (i_ack[n] && !set_edge[n]) begin
                out_nxt[n] = 1'b0;
            end

            if (i_ack[n]) begin
                cnt_nxt[n] = '0;
            end else if (set_edge[n] && o_out[n] && out_nxt[n] && (cnt_q[n] != CNT_MAX)) begin
                cnt_nxt[n] = cnt_q[n] + 1'b1;
            end

            if (!run) begin
                out_nxt[n] = 1'b0;
                cnt_nxt[n] = '0;
            end

            flag_nxt[n] = |cnt_nxt[n];
        end
    end

    // Register latch state, counters and the summary flags taken from next-state values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_out      <= '0;
            cnt_q      <= '0;
            o_any      <= 1'b0;
            o_ovr_flag <= '0;
        end else begin
            o_out      <= out_nxt;
            cnt_q      <= cnt_nxt;
            o_any      <= |out_nxt;
            o_ovr_flag <= flag_nxt;
        end
    end

    assign o_ovr = cnt_q;

endmodule

// File: tb/tb_edge_latch_bank.sv
// Testbench for edge_latch_bank: two configurations share one stimulus stream.
// A reference model predicts every output on every clock and a monitor compares.
module tb_edge_latch_bank;

    localparam int           W     = 4;
    localparam int           CW    = 4;
    localparam int           CMAX  = (1 << CW) - 1;
    localparam logic [W-1:0] POL_B = 4'b0111;

    logic            clk    = 1'b0;
    logic            rst    = 1'b1;
    logic [W-1:0]    set_in = '0;
    logic [W-1:0]    clr_in = '0;
    logic [W-1:0]    ack_in = '0;

    logic [W-1:0]    out_a, out_b, flag_a, flag_b;
    logic            any_a, any_b;
    logic [W*CW-1:0] ovr_a, ovr_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // a: no synchroniser, clear wins. b: two stages, channel 3 sets on falling edges, set wins.
    edge_latch_bank #(.W(W), .CW(CW), .SYNC_STAGES(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_set(set_in), .i_clear(clr_in), .i_ack(ack_in),
        .o_out(out_a), .o_any(any_a), .o_ovr(ovr_a), .o_ovr_flag(flag_a)
    );

    edge_latch_bank #(.W(W), .CW(CW), .SYNC_STAGES(2), .SET_POL(POL_B), .SET_WINS(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_set(set_in), .i_clear(clr_in), .i_ack(ack_in),
        .o_out(out_b), .o_any(any_b), .o_ovr(ovr_b), .o_ovr_flag(flag_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0]    out_a;
        logic            any_a;
        logic [W*CW-1:0] ovr_a;
        logic [W-1:0]    flag_a;
        logic [W-1:0]    out_b;
        logic            any_b;
        logic [W*CW-1:0] ovr_b;
        logic [W-1:0]    flag_b;
    } exp_t;

    exp_t         exp_q [$];
    logic [W-1:0] set_samp [$];
    logic [W-1:0] clr_samp [$];

    int           stg  [2] = '{0, 2};
    logic [W-1:0] spol [2] = '{4'b1111, POL_B};
    bit           wins [2] = '{1'b0, 1'b1};

    bit m_out [2][W];
    int m_cnt [2][W];

    int rst_events = 0;
    int rst_seen   = 0;

    always @(posedge rst) rst_events++;

    // The level a configuration sees at clock k is the sample from k-stages;
    // edges exist only once two post-reset samples have reached that point.
    task automatic model_step(input int d, input logic [W-1:0] ack);
        int k, ci, pi;
        logic [W-1:0] sc, sp, cc, cp;
        k  = set_samp.size();
        ci = k - stg[d] - 1;
        pi = ci - 1;
        if (pi < 0) return;
        sc = set_samp[ci];
        sp = set_samp[pi];
        cc = clr_samp[ci];
        cp = clr_samp[pi];
        for (int c = 0; c < W; c++) begin
            bit s, cl, nxt;
            s  = spol[d][c] ? (sc[c] && !sp[c]) : (!sc[c] && sp[c]);
            cl = cc[c] && !cp[c];
            nxt = m_out[d][c];
            if (s && cl) nxt = wins[d];
            else if (s)  nxt = 1'b1;
            else if (cl) nxt = 1'b0;
            if (ack[c] && !s) nxt = 1'b0;
            if (ack[c]) m_cnt[d][c] = 0;
            else if (s && m_out[d][c] && nxt && m_cnt[d][c] < CMAX) m_cnt[d][c] = m_cnt[d][c] + 1;
            m_out[d][c] = nxt;
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic [W-1:0]    o [2];
        logic [W*CW-1:0] v [2];
        logic [W-1:0]    f [2];
        if (rst || rst_events != rst_seen) begin
            rst_seen = rst_events;
            set_samp.delete();
            clr_samp.delete();
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < W; c++) begin
                    m_out[d][c] = 1'b0;
                    m_cnt[d][c] = 0;
                end
        end
        if (!rst) begin
            set_samp.push_back(set_in);
            clr_samp.push_back(clr_in);
            model_step(0, ack_in);
            model_step(1, ack_in);
        end
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < W; c++) begin
                o[d][c]           = m_out[d][c];
                v[d][c*CW +: CW]  = CW'(m_cnt[d][c]);
                f[d][c]           = (m_cnt[d][c] != 0);
            end
        end
        e.out_a = o[0]; e.any_a = |o[0]; e.ovr_a = v[0]; e.flag_a = f[0];
        e.out_b = o[1]; e.any_b = |o[1]; e.ovr_b = v[1]; e.flag_b = f[1];
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_a",  out_a,  e.out_a);
                check("any_a",  any_a,  e.any_a);
                check("ovr_a",  ovr_a,  e.ovr_a);
                check("flag_a", flag_a, e.flag_a);
                check("out_b",  out_b,  e.out_b);
                check("any_b",  any_b,  e.any_b);
                check("ovr_b",  ovr_b,  e.ovr_b);
                check("flag_b", flag_b, e.flag_b);
            end
        end
    end

    task automatic random_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            set_in = W'($urandom);
            clr_in = W'($urandom) & W'($urandom);
            for (int c = 0; c < W; c++) ack_in[c] = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        set_in = '0;
        clr_in = '0;
        ack_in = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Channel 2 set held high through reset: must never latch from it.
        set_in = 4'b0100;
        repeat (3) @(negedge clk);
        check("reset_out_a", out_a, 4'b0000);
        check("reset_ovr_b", ovr_b, '0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("held_set_a2", out_a[2], 1'b0);
        check("held_set_b2", out_b[2], 1'b0);

        // Single set pulse on channel 0 shows up on the sampling edge itself.
        set_in[0] = 1'b1;
        @(posedge clk);
        #1;
        check("first_set_out_a", out_a, 4'b0001);
        check("first_set_any_a", any_a, 1'b1);
        check("first_set_ovr_a", ovr_a, '0);
        @(negedge clk);
        set_in[0] = 1'b0;

        // Channel 2: 1 -> 0 -> 1 gives a real rising edge.
        @(negedge clk);
        set_in[2] = 1'b0;
        @(negedge clk);
        set_in[2] = 1'b1;
        repeat (4) @(negedge clk);
        check("retoggle_a2", out_a[2], 1'b1);
        check("retoggle_b2", out_b[2], 1'b1);

        // Twenty further set pulses on latched channel 0 saturate the counter.
        for (int i = 0; i < 20; i++) begin
            set_in[0] = 1'b1;
            @(negedge clk);
            set_in[0] = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("sat_ovr_a0",  ovr_a[3:0], 4'd15);
        check("sat_flag_a0", flag_a[0],  1'b1);
        check("sat_ovr_b0",  ovr_b[3:0], 4'd15);
        ack_in[0] = 1'b1;
        @(negedge clk);
        ack_in[0] = 1'b0;
        check("ack_out_a0",  out_a[0],   1'b0);
        check("ack_ovr_a0",  ovr_a[3:0], 4'd0);
        check("ack_flag_a0", flag_a[0],  1'b0);
        repeat (4) @(negedge clk);

        // Simultaneous set and clear rising edges on channel 1.
        set_in[1] = 1'b1;
        clr_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        check("both_a1", out_a[1], 1'b0);
        check("both_b1", out_b[1], 1'b1);
        set_in[1] = 1'b0;
        clr_in[1] = 1'b0;
        @(negedge clk);

        // Latch channel 1, overrun once, then ack together with a set edge.
        for (int i = 0; i < 2; i++) begin
            set_in[1] = 1'b1;
            @(negedge clk);
            set_in[1] = 1'b0;
            @(negedge clk);
        end
        check("pre_ack_ovr_a1", ovr_a[7:4], 4'd1);
        set_in[1] = 1'b1;
        ack_in[1] = 1'b1;
        @(negedge clk);
        ack_in[1] = 1'b0;
        set_in[1] = 1'b0;
        check("ack_set_out_a1", out_a[1], 1'b1);
        check("ack_set_ovr_a1", ovr_a[7:4], 4'd0);
        repeat (4) @(negedge clk);

        // Channel 3 on b sets on a falling edge, two clocks behind a.
        set_in[3] = 1'b1;
        repeat (4) @(negedge clk);
        check("rise_no_set_b3", out_b[3], 1'b0);
        set_in[3] = 1'b0;
        @(posedge clk); #1;
        check("fall_b3_edge1", out_b[3], 1'b0);
        @(posedge clk); #1;
        check("fall_b3_edge2", out_b[3], 1'b0);
        @(posedge clk); #1;
        check("fall_b3_edge3", out_b[3], 1'b1);
        @(negedge clk);

        random_phase(400);

        // Drive every channel to 1 on both configurations.
        repeat (4) @(negedge clk);
        set_in = '1;
        repeat (4) @(negedge clk);
        set_in = '0;
        repeat (5) @(negedge clk);
        check("all_set_a", out_a, 4'b1111);
        check("all_set_b", out_b, 4'b1111);

        // Put a fresh edge into b's synchroniser, then reset between clock edges.
        set_in[0] = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int c = 0; c < W; c++) begin
            check($sformatf("async_out_a%0d", c),  out_a[c],            1'b0);
            check($sformatf("async_out_b%0d", c),  out_b[c],            1'b0);
            check($sformatf("async_ovr_a%0d", c),  ovr_a[c*CW +: CW],   '0);
            check($sformatf("async_ovr_b%0d", c),  ovr_b[c*CW +: CW],   '0);
            check($sformatf("async_flag_a%0d", c), flag_a[c],           1'b0);
            check($sformatf("async_flag_b%0d", c), flag_b[c],           1'b0);
        end
        check("async_any_a", any_a, 1'b0);
        check("async_any_b", any_b, 1'b0);
        set_in[0] = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_reset_b", out_b, 4'b0000);

        random_phase(200);
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
